pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared state encoding and default parameter values for the program counter unit.
// Default values are widened to 64 bits here; each instance casts them to its own WIDTH.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

    localparam int          PC_WIDTH      = 64;
    localparam logic [63:0] PC_RESET_VEC  = 64'h0;
    localparam int          PC_INC        = 4;
    localparam int          PC_ALIGN_BITS = 2;
    localparam int          PC_RAS_DEPTH  = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating count.
// Latency: a push or pop is visible on top/empty/full one cycle later.
// Backpressure: none. A push when full overwrites the oldest entry; a pop when empty is dropped.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_ptr;
    logic [PW:0]      count;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign top    = mem[top_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && do_pop) begin
            // Push and pop together replace the top in place.
            top_ptr <= top_ptr;
        end else if (push) begin
            top_ptr <= top_ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (do_pop) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && do_pop)
            mem[top_ptr] <= push_data;
        else if (push)
            mem[top_ptr + 1'b1] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/exception/return redirects and alignment faulting; PC_RAS_EN builds the return stack.
// Latency: one cycle from qualified inputs to pc.
// Backpressure: write=0 stalls pc and the stack; exc overrides the stall.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH      = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(PC_RESET_VEC),
    parameter int               INC        = PC_INC,
    parameter int               ALIGN_BITS = PC_ALIGN_BITS,
    parameter int               RAS_DEPTH  = PC_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    input  logic [WIDTH-1:0] exc_vec,
    output logic [WIDTH-1:0] pc,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, seq_pc, tgt;
    logic             misalign_q, misalign_d;

    assign seq_pc = pc_q + WIDTH'(INC);

`ifdef PC_RAS_EN
    logic             ras_push, ras_pop, ras_hit;
    logic [WIDTH-1:0] ras_top;

    assign ras_hit = ret && !ras_empty;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    logic unused_ras;
    assign unused_ras = call ^ ret;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        tgt        = seq_pc;
`ifdef PC_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
`endif
        if (exc) begin
            // Exception vectors are trusted; they always load and clear a fault.
            pc_d       = exc_vec;
            misalign_d = 1'b0;
            state_d    = RUN;
        end else begin
            case (state_q)
                BOOT:  state_d = RUN;
                RUN: begin
                    if (write) begin
`ifdef PC_RAS_EN
                        if (ras_hit)
                            tgt = ras_top;
                        else
`endif
                        if (br_taken)
                            tgt = br_target;
                        else
                            tgt = seq_pc;
                        // A faulting redirect leaves pc and the stack untouched.
                        if ((tgt & ALIGN_MASK) != '0) begin
                            misalign_d = 1'b1;
                            state_d    = FAULT;
                        end else begin
                            pc_d = tgt;
`ifdef PC_RAS_EN
                            ras_push = call;
                            ras_pop  = ras_hit;
`endif
                        end
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = BOOT;
            endcase
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule
